// File: rtl/fwft_fifo_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwft_fifo_packer_pkg
//  Description : Shared constants and the clog2 helper used by the FWFT
//                FIFO stream blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwft_fifo_packer_pkg;

    // Default stream geometry: one 32-bit FIFO word, four words per beat.
    localparam int unsigned c_def_dwidth = 32;
    localparam int unsigned c_def_ratio  = 4;

    // Ceiling log2; returns the number of bits needed to index 'value' items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwft_fifo_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fwft_fifo_packer
//  Description : Drains a first-word-fall-through FIFO and packs RATIO
//                consecutive DWIDTH-bit words into one wide valid/ready beat.
//                A flush pulse emits a partial beat with its word count.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwft_fifo_packer
    import fwft_fifo_packer_pkg::*;
#(
    parameter  int DWIDTH = c_def_dwidth,
    parameter  int RATIO  = c_def_ratio,
    localparam int CW     = clog2(RATIO + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        fifo_dout,
    input  logic                     fifo_empty,
    output logic                     fifo_read,
    input  logic                     flush,
    output logic [DWIDTH*RATIO-1:0]  out_data,
    output logic [CW-1:0]            out_count,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int            c_aw   = DWIDTH * RATIO;
    localparam logic [CW-1:0] c_full = CW'(RATIO);

    logic [c_aw-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [c_aw-1:0] out_data_q, out_data_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            out_valid_q, out_valid_d;

    logic            w_xfer;
    logic            w_pop;
    logic [CW-1:0]   w_slot;

    // A beat moves to the output register when the accumulator is full, or
    // holds a partial word under a pending flush, and the output slot is free
    // or being drained this cycle.
    assign w_xfer = ((cnt_q == c_full) | (flush_pend_q & (cnt_q != '0)))
                  & (~out_valid_q | out_ready);

    // Pop whenever there is room, including the slot freed by a same-cycle
    // transfer; pops pause while a flush is waiting to drain.
    assign w_pop  = ~rst & ~fifo_empty & ~flush_pend_q
                  & ((cnt_q < c_full) | w_xfer);

    assign fifo_read = w_pop;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;

    // Accumulator next state: clear on transfer, then write any popped word
    // into the next free slot (slot 0 of the fresh accumulator on transfer).
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        w_slot = w_xfer ? '0 : cnt_q;
        if (w_xfer) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (w_pop) begin
            for (int i = 0; i < RATIO; i++) begin
                if (w_slot == CW'(i)) begin
                    acc_d[i*DWIDTH +: DWIDTH] = fifo_dout;
                end
            end
            cnt_d = w_slot + CW'(1);
        end
    end

    // Flush tracking and output register next state.
    always_comb begin
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_valid_d  = out_valid_q;

        // A repeated flush while one is pending is absorbed; an empty
        // accumulator retires the flush without producing an empty beat.
        if (flush & ~flush_pend_q) begin
            flush_pend_d = 1'b1;
        end else if (w_xfer | (flush_pend_q & (cnt_q == '0))) begin
            flush_pend_d = 1'b0;
        end

        if (w_xfer) begin
            out_data_d  = acc_q;
            out_count_d = cnt_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding all buffered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwft_fifo_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fwft_fifo_packer
//  Description : Self-checking bench for fwft_fifo_packer. A behavioural FWFT
//                source feeds the DUT; expected beats are queued as stimulus
//                is driven and compared against captured output beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwft_fifo_packer;

    localparam int DW  = 32;
    localparam int RT  = 4;
    localparam int AW  = DW * RT;
    localparam int CWT = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b1;
    logic          src_hold  = 1'b0;
    logic          fifo_empty;
    logic          fifo_read;
    logic          out_valid;
    logic [DW-1:0] fifo_dout;
    logic [AW-1:0] out_data;
    logic [CWT-1:0] out_count;

    // Behavioural FWFT source: head word always visible while non-empty.
    logic [DW-1:0] src_mem [0:2047];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            cyc    = 0;

    assign fifo_empty = (wr_ptr == rd_ptr) | src_hold;
    assign fifo_dout  = src_mem[rd_ptr[10:0]];

    fwft_fifo_packer #(.DWIDTH(DW), .RATIO(RT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .flush      (flush),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Cycle counter and source pop pointer.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read) rd_ptr <= rd_ptr + 1;
    end

    // Capture every accepted output beat.
    logic [AW-1:0]  obs_data [0:1023];
    logic [CWT-1:0] obs_cnt  [0:1023];
    int             obs_cyc  [0:1023];
    int             obs_wr = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_data[obs_wr[9:0]] <= out_data;
            obs_cnt[obs_wr[9:0]]  <= out_count;
            obs_cyc[obs_wr[9:0]]  <= cyc;
            obs_wr                <= obs_wr + 1;
        end
    end

    typedef struct {
        logic [AW-1:0]  d;
        logic [CWT-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   obs_rd = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        src_mem[wr_ptr[10:0]] = w;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [AW-1:0] d, input logic [CWT-1:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    function automatic logic [AW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (obs_wr - obs_rd >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit   ok;
        exp_t e;
        rst = 1'b1;
        push(32'h0000_0055);
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_fifo_read: got %b want 0", fifo_read); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word(128'h55, 3'd1);
        wait_out(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL reset_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL reset_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL reset_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_basic();
        bit   ok;
        exp_t e;
        int   pops = 0;
        int   c4   = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        expect_word(128'h00000004_00000003_00000002_00000001, 3'd4);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (fifo_read) begin
                pops++;
                if (pops == 4) c4 = cyc;
            end
        end
        wait_out(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        if (obs_rd != obs_wr) begin
            n_cmp++; if (obs_cyc[obs_rd[9:0]] - c4 != 2) begin n_err++; $display("FAIL basic_latency: got %0d cycles want 2", obs_cyc[obs_rd[9:0]] - c4); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL basic_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL basic_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL basic_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        int   pops = 0;
        int   gaps = 0;
        int   sp_err = 0;
        int   prev = -1;
        logic [DW-1:0] w [0:3];
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) push(32'h1000 + DW'(i));
        for (int g = 0; g < 100; g++) begin
            for (int j = 0; j < 4; j++) w[j] = 32'h1000 + DW'(4 * g + j);
            expect_word(pack4(w[0], w[1], w[2], w[3]), 3'd4);
        end
        for (int k = 0; k < 500 && pops < 400; k++) begin
            @(negedge clk);
            if (fifo_read) pops++;
            else if (pops > 0) gaps++;
        end
        n_cmp++; if (pops != 400) begin n_err++; $display("FAIL b2b_pops: got %0d want 400", pops); end
        n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL b2b_read_gaps: got %0d want 0", gaps); end
        wait_out(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL b2b_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL b2b_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                if (prev >= 0 && obs_cyc[obs_rd[9:0]] - prev != 4) sp_err++;
                prev = obs_cyc[obs_rd[9:0]];
                obs_rd++;
            end
        end
        n_cmp++; if (sp_err != 0) begin n_err++; $display("FAIL b2b_spacing: got %0d irregular gaps want 0", sp_err); end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL b2b_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_flush();
        bit   ok;
        exp_t e;
        push(32'hA);
        push(32'hB);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word(128'h0000000B_0000000A, 3'd2);
        for (int i = 0; i < 4; i++) push(32'h21 + DW'(i));
        expect_word(pack4(32'h21, 32'h22, 32'h23, 32'h24), 3'd4);
        wait_out(30, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL flush_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL flush_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL flush_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL flush_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_flush_corner();
        bit   ok;
        exp_t e;
        // Flush with nothing accumulated must not produce a beat.
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL flush_empty_output: got %0d words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
        // Flush in the same cycle as the pop of the third word.
        push(32'hA);
        push(32'hB);
        repeat (4) tick();
        push(32'hC);
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_read !== 1'b1) begin n_err++; $display("FAIL flush_same_cycle_pop: got %b want 1", fifo_read); end
        tick();
        flush = 1'b0;
        // Queued while the flush is pending: must land in the next beat.
        for (int i = 0; i < 4; i++) push(32'hD0 + DW'(i));
        expect_word(128'h0000000C_0000000B_0000000A, 3'd3);
        expect_word(pack4(32'hD0, 32'hD1, 32'hD2, 32'hD3), 3'd4);
        wait_out(30, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL corner_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL corner_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL corner_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL corner_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_backpressure();
        bit            ok;
        exp_t          e;
        int            pops = 0;
        int            changes = 0;
        bit            seen = 1'b0;
        logic [AW-1:0] held = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(32'h300 + DW'(i));
        for (int g = 0; g < 3; g++)
            expect_word(pack4(32'h300 + DW'(4*g), 32'h301 + DW'(4*g), 32'h302 + DW'(4*g), 32'h303 + DW'(4*g)), 3'd4);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_read) pops++;
            if (out_valid) begin
                if (!seen) begin held = out_data; seen = 1'b1; end
                else if (out_data !== held) changes++;
            end
        end
        n_cmp++; if (pops != 8) begin n_err++; $display("FAIL bp_pops: got %0d want 8", pops); end
        n_cmp++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL bp_fifo_read: got %b want 0", fifo_read); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (held !== pack4(32'h300, 32'h301, 32'h302, 32'h303)) begin n_err++; $display("FAIL bp_held_data: got %h want first beat", held); end
        n_cmp++; if (changes != 0) begin n_err++; $display("FAIL bp_data_stable: got %0d changes want 0", changes); end
        tick();
        out_ready = 1'b1;
        wait_out(30, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL bp_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL bp_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL bp_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(32'h400 + DW'(i));
        repeat (14) tick();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("FAIL rstmid_out_count: got %0d want 0", out_count); end
        tick();
        for (int i = 0; i < 4; i++) push(32'h480 + DW'(i));
        expect_word(pack4(32'h480, 32'h481, 32'h482, 32'h483), 3'd4);
        wait_out(30, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL rstmid_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL rstmid_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL rstmid_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    task automatic test_random_gaps();
        bit   ok;
        exp_t e;
        for (int i = 0; i < 40; i++) push(32'h500 + DW'(i));
        for (int g = 0; g < 10; g++)
            expect_word(pack4(32'h500 + DW'(4*g), 32'h501 + DW'(4*g), 32'h502 + DW'(4*g), 32'h503 + DW'(4*g)), 3'd4);
        for (int k = 0; k < 600 && (obs_wr - obs_rd) < 10; k++) begin
            src_hold  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        src_hold  = 1'b0;
        out_ready = 1'b1;
        wait_out(60, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_timeout: got %0d words want %0d", obs_wr - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_rd == obs_wr) begin n_err++; $display("FAIL rand_missing: got none want %h/%0d", e.d, e.c); end
            else begin
                if (obs_data[obs_rd[9:0]] !== e.d || obs_cnt[obs_rd[9:0]] !== e.c) begin n_err++; $display("FAIL rand_word: got %h/%0d want %h/%0d", obs_data[obs_rd[9:0]], obs_cnt[obs_rd[9:0]], e.d, e.c); end
                obs_rd++;
            end
        end
        repeat (6) tick();
        n_cmp++; if (obs_wr != obs_rd) begin n_err++; $display("FAIL rand_extra: got %0d extra words want 0", obs_wr - obs_rd); obs_rd = obs_wr; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_flush_corner();
        test_backpressure();
        test_reset_mid();
        test_random_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
